// File: rtl/hamming_secded_stream.sv
// Two-stage valid/ready Hamming SECDED codec: encode or decode per transaction,
// with saturating counters of corrected and uncorrectable decodes.
module hamming_secded_stream #(
    parameter  int DATA_W = 4,
    parameter  int CNT_W  = 8,
    localparam int PAR_W  = (DATA_W <= 4)  ? 3 :
                            (DATA_W <= 11) ? 4 :
                            (DATA_W <= 26) ? 5 :
                            (DATA_W <= 57) ? 6 : 7,
    localparam int CODE_W = DATA_W + PAR_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_mode,
    input  logic [CODE_W-1:0] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_mode,
    output logic [CODE_W-1:0] out_word,
    output logic [1:0]        out_err,
    output logic [PAR_W-1:0]  out_syndrome,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  cnt_corr,
    output logic [CNT_W-1:0]  cnt_uncorr
);

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_CORR = 2'b01;
    localparam logic [1:0] ERR_UNCR = 2'b10;

    function automatic logic is_pow2(input int p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic logic [PAR_W-1:0] calc_syndrome(input logic [CODE_W-1:0] c);
        logic [PAR_W-1:0] s;
        s = '0;
        for (int i = 1; i < CODE_W; i++) begin
            if (c[i]) s = s ^ PAR_W'(i);
        end
        return s;
    endfunction

    function automatic logic [CODE_W-1:0] encode(input logic [DATA_W-1:0] d);
        logic [CODE_W-1:0] c;
        logic              par;
        int                j;
        c = '0;
        j = 0;
        for (int i = 1; i < CODE_W; i++) begin
            if (!is_pow2(i)) begin
                c[i] = d[j];
                j++;
            end
        end
        // Parity slots are still zero here, so they do not disturb their own sums.
        for (int k = 0; k < PAR_W; k++) begin
            par = 1'b0;
            for (int i = 1; i < CODE_W; i++) begin
                if (i[k]) par = par ^ c[i];
            end
            c[1 << k] = par;
        end
        c[0] = ^c[CODE_W-1:1];
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] extract(input logic [CODE_W-1:0] c);
        logic [DATA_W-1:0] d;
        int                j;
        d = '0;
        j = 0;
        for (int i = 1; i < CODE_W; i++) begin
            if (!is_pow2(i)) begin
                d[j] = c[i];
                j++;
            end
        end
        return d;
    endfunction

    function automatic logic [CODE_W-1:0] flip_bit(input logic [CODE_W-1:0] c,
                                                   input logic [PAR_W-1:0]  pos);
        logic [CODE_W-1:0] r;
        r = c;
        for (int i = 0; i < CODE_W; i++) begin
            if (int'(pos) == i) r[i] = ~r[i];
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic              vld_p1_q, vld_p1_d;
    logic              mode_p1_q;
    logic [CODE_W-1:0] word_p1_q;
    logic [PAR_W-1:0]  syn_p1_q;
    logic              op_p1_q;

    logic              vld_p2_q, vld_p2_d;
    logic              mode_p2_q;
    logic [CODE_W-1:0] word_p2_q, word_p2_d;
    logic [1:0]        err_p2_q, err_p2_d;
    logic [PAR_W-1:0]  syn_p2_q, syn_p2_d;
    logic [CODE_W-1:0] fixed_p2;

    logic [CNT_W-1:0]  cnt_corr_q, cnt_corr_d;
    logic [CNT_W-1:0]  cnt_uncorr_q, cnt_uncorr_d;

    logic              s1_advance;
    logic              s1_load;
    logic              s2_load;
    logic              out_fire;

    always_comb begin
        s1_advance = !vld_p2_q | out_ready;
        in_ready   = !vld_p1_q | s1_advance;
        s1_load    = in_valid & in_ready;
        s2_load    = vld_p1_q & s1_advance;
        vld_p1_d   = in_ready ? in_valid : vld_p1_q;
        vld_p2_d   = s1_advance ? vld_p1_q : vld_p2_q;
        out_fire   = vld_p2_q & out_ready;
    end

    // Stage 1: capture the transaction with its syndrome and overall parity.
    always_ff @(posedge clk) begin
        if (s1_load) begin
            mode_p1_q <= in_mode;
            word_p1_q <= in_word;
            syn_p1_q  <= calc_syndrome(in_word);
            op_p1_q   <= ^in_word;
        end
    end

    always_comb begin
        fixed_p2  = word_p1_q;
        word_p2_d = '0;
        err_p2_d  = ERR_NONE;
        syn_p2_d  = '0;
        if (!mode_p1_q) begin
            word_p2_d = encode(word_p1_q[DATA_W-1:0]);
        end else begin
            syn_p2_d = syn_p1_q;
            if (op_p1_q) begin
                // Odd parity with an in-range syndrome is a single flip, including code[0].
                if (int'(syn_p1_q) < CODE_W) begin
                    fixed_p2 = flip_bit(word_p1_q, syn_p1_q);
                    err_p2_d = ERR_CORR;
                end else begin
                    err_p2_d = ERR_UNCR;
                end
            end else if (syn_p1_q != '0) begin
                err_p2_d = ERR_UNCR;
            end
            word_p2_d = CODE_W'(extract(fixed_p2));
        end
    end

    always_comb begin
        cnt_corr_d   = cnt_corr_q;
        cnt_uncorr_d = cnt_uncorr_q;
        if (cnt_clr) begin
            cnt_corr_d   = '0;
            cnt_uncorr_d = '0;
        end else if (out_fire && mode_p2_q) begin
            if (err_p2_q == ERR_CORR) cnt_corr_d   = sat_inc(cnt_corr_q);
            if (err_p2_q == ERR_UNCR) cnt_uncorr_d = sat_inc(cnt_uncorr_q);
        end
    end

    // Stage 2: corrected result and status, held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1_q     <= 1'b0;
            vld_p2_q     <= 1'b0;
            mode_p2_q    <= 1'b0;
            word_p2_q    <= '0;
            err_p2_q     <= ERR_NONE;
            syn_p2_q     <= '0;
            cnt_corr_q   <= '0;
            cnt_uncorr_q <= '0;
        end else begin
            vld_p1_q     <= vld_p1_d;
            vld_p2_q     <= vld_p2_d;
            cnt_corr_q   <= cnt_corr_d;
            cnt_uncorr_q <= cnt_uncorr_d;
            if (s2_load) begin
                mode_p2_q <= mode_p1_q;
                word_p2_q <= word_p2_d;
                err_p2_q  <= err_p2_d;
                syn_p2_q  <= syn_p2_d;
            end
        end
    end

    assign out_valid    = vld_p2_q;
    assign out_mode     = mode_p2_q;
    assign out_word     = word_p2_q;
    assign out_err      = err_p2_q;
    assign out_syndrome = syn_p2_q;
    assign cnt_corr     = cnt_corr_q;
    assign cnt_uncorr   = cnt_uncorr_q;

endmodule

// File: tb/tb_hamming_secded_stream.sv
// Scoreboard bench: directed cases on a DATA_W=4/CNT_W=2 instance plus
// randomized flip sweeps on DATA_W = 4, 8, 26 and 64 instances.
module tb_hamming_secded_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_sw_n;
    int   checks = 0;
    int   errors = 0;

    logic       in_valid, in_ready, in_mode;
    logic [7:0] in_word;
    logic       out_valid, out_ready, out_mode;
    logic [7:0] out_word;
    logic [1:0] out_err;
    logic [2:0] out_syndrome;
    logic       cnt_clr;
    logic [1:0] cnt_corr, cnt_uncorr;

    hamming_secded_stream #(.DATA_W(4), .CNT_W(2)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
        .out_word(out_word), .out_err(out_err), .out_syndrome(out_syndrome),
        .cnt_clr(cnt_clr), .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    function automatic int par_w(input int dw);
        int r;
        r = 8;
        for (int p = 7; p >= 1; p--) begin
            if ((1 << p) >= dw + p + 1) r = p;
        end
        return r;
    endfunction

    // Reference: parity bits are chosen so the XOR of set-bit indices becomes zero.
    function automatic logic [127:0] m_encode(input logic [63:0] d, input int dw);
        logic [127:0] c;
        logic [7:0]   s;
        int           j, cw, pw;
        pw = par_w(dw);
        cw = dw + pw + 1;
        c = '0;
        s = '0;
        j = 0;
        for (int pos = 1; pos < cw; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                c[pos] = d[j];
                if (d[j]) s = s ^ 8'(pos);
                j++;
            end
        end
        for (int k = 0; k < pw; k++) c[1 << k] = s[k];
        c[0] = ^c;
        return c;
    endfunction

    function automatic logic [63:0] m_extract(input logic [127:0] c, input int cw);
        logic [63:0] d;
        int          j;
        d = '0;
        j = 0;
        for (int pos = 1; pos < cw; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                d[j] = c[pos];
                j++;
            end
        end
        return d;
    endfunction

    logic [7:0] mq_w[$];
    logic [1:0] mq_e[$];
    logic [2:0] mq_s[$];
    logic       mq_m[$];

    task automatic send(input logic m, input logic [7:0] w, input logic [7:0] ew,
                        input logic [1:0] ee, input logic [2:0] es);
        int n;
        in_valid = 1'b1;
        in_mode  = m;
        in_word  = w;
        #1;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL main_accept: in_ready stayed %0b, required 1", in_ready);
        end else begin
            mq_w.push_back(ew);
            mq_e.push_back(ee);
            mq_s.push_back(es);
            mq_m.push_back(m);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (mq_w.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (mq_w.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL main_drain: %0d outputs outstanding, required 0", mq_w.size());
        end
        @(negedge clk);
    endtask

    initial begin : main_mon
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && out_valid && out_ready) begin
                if (mq_w.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL main_extra: output %0h appeared, required none", out_word);
                end else begin
                    chk("main_word", out_word, mq_w.pop_front());
                    chk("main_err", out_err, mq_e.pop_front());
                    chk("main_syndrome", out_syndrome, mq_s.pop_front());
                    chk("main_mode", out_mode, mq_m.pop_front());
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int DW = (g == 0) ? 4 : (g == 1) ? 8 : (g == 2) ? 26 : 64;
        localparam int PW = (DW <= 4) ? 3 : (DW <= 11) ? 4 : (DW <= 26) ? 5 : (DW <= 57) ? 6 : 7;
        localparam int CW = DW + PW + 1;

        logic          iv, ir, im, ov, ordy, om;
        logic [CW-1:0] iw, ow;
        logic [1:0]    oe;
        logic [PW-1:0] osy;
        logic [7:0]    cc, cu;
        logic [127:0]  qw[$];
        logic [1:0]    qe[$];
        logic [7:0]    qs[$];
        logic          qm[$];
        int            exp_cc = 0;
        int            exp_cu = 0;
        logic          done = 1'b0;

        hamming_secded_stream #(.DATA_W(DW), .CNT_W(8)) u_sw (
            .clk(clk), .rst_n(rst_sw_n),
            .in_valid(iv), .in_ready(ir), .in_mode(im), .in_word(iw),
            .out_valid(ov), .out_ready(ordy), .out_mode(om),
            .out_word(ow), .out_err(oe), .out_syndrome(osy),
            .cnt_clr(1'b0), .cnt_corr(cc), .cnt_uncorr(cu)
        );

        initial begin : rdy
            ordy = 1'b0;
            forever begin
                @(negedge clk);
                ordy = ($urandom_range(0, 2) != 0);
            end
        end

        initial begin : mon
            logic [1:0] e;
            logic       m;
            forever begin
                @(negedge clk);
                #2;
                if (rst_sw_n && ov && ordy) begin
                    if (qw.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL w%0d_extra: output %0h appeared, required none", DW, ow);
                    end else begin
                        e = qe.pop_front();
                        m = qm.pop_front();
                        chk($sformatf("w%0d_word", DW), ow, qw.pop_front());
                        chk($sformatf("w%0d_err", DW), oe, e);
                        chk($sformatf("w%0d_syndrome", DW), osy, qs.pop_front());
                        chk($sformatf("w%0d_mode", DW), om, m);
                        if (m && e == 2'b01 && exp_cc < 255) exp_cc++;
                        if (m && e == 2'b10 && exp_cu < 255) exp_cu++;
                    end
                end
            end
        end

        initial begin : drv
            logic [63:0]  d;
            logic [127:0] cwv, cor, fx, r, ew, mask;
            logic [1:0]   ee;
            logic [7:0]   s;
            logic         mode;
            int           nf, n;
            int           p[3];
            iv = 1'b0;
            im = 1'b0;
            iw = '0;
            wait (rst_sw_n == 1'b1);
            @(negedge clk);
            for (int t = 0; t < 250; t++) begin
                d    = {$urandom(), $urandom()};
                d    = d & ((64'd1 << DW) - 64'd1);
                cwv  = m_encode(d, DW);
                mode = 1'($urandom_range(0, 1));
                s    = '0;
                ee   = 2'b00;
                if (!mode) begin
                    mask = (128'd1 << DW) - 128'd1;
                    r    = {$urandom(), $urandom(), $urandom(), $urandom()};
                    r    = (r & ~mask) | {64'd0, d};
                    iw   = r[CW-1:0];
                    ew   = cwv;
                end else begin
                    nf   = $urandom_range(0, 3);
                    p[0] = $urandom_range(0, CW - 1);
                    p[1] = p[0];
                    while (p[1] == p[0]) p[1] = $urandom_range(0, CW - 1);
                    p[2] = p[0];
                    while (p[2] == p[0] || p[2] == p[1]) p[2] = $urandom_range(0, CW - 1);
                    cor = cwv;
                    for (int i = 0; i < nf; i++) begin
                        cor[p[i]] = ~cor[p[i]];
                        s = s ^ 8'(p[i]);
                    end
                    case (nf)
                        0: begin ew = {64'd0, d}; ee = 2'b00; end
                        1: begin ew = {64'd0, d}; ee = 2'b01; end
                        2: begin ew = {64'd0, m_extract(cor, CW)}; ee = 2'b10; end
                        default: begin
                            if (int'(s) < CW) begin
                                fx = cor;
                                fx[s] = ~fx[s];
                                ew = {64'd0, m_extract(fx, CW)};
                                ee = 2'b01;
                            end else begin
                                ew = {64'd0, m_extract(cor, CW)};
                                ee = 2'b10;
                            end
                        end
                    endcase
                    iw = cor[CW-1:0];
                end
                iv = 1'b1;
                im = mode;
                #1;
                n = 0;
                while (!ir && n < 200) begin
                    @(negedge clk);
                    #1;
                    n++;
                end
                if (!ir) begin
                    checks++;
                    errors++;
                    $display("FAIL w%0d_accept: in_ready stayed %0b, required 1", DW, ir);
                end else begin
                    qw.push_back(ew);
                    qe.push_back(ee);
                    qs.push_back(s);
                    qm.push_back(mode);
                end
                @(negedge clk);
                iv = 1'b0;
                if ($urandom_range(0, 3) == 0) @(negedge clk);
            end
            n = 0;
            while (qw.size() != 0 && n < 1000) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            chk($sformatf("w%0d_outstanding", DW), qw.size(), 0);
            chk($sformatf("w%0d_cnt_corr", DW), cc, exp_cc);
            chk($sformatf("w%0d_cnt_uncorr", DW), cu, exp_cu);
            done = 1'b1;
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation still running at time limit, required completion");
        $fatal(1, "time limit reached");
    end

    initial begin : directed
        logic [127:0] tmp;
        logic [7:0]   e1, e2, e3;
        logic [3:0]   dd;
        time          t0;
        int           n;

        rst_n     = 1'b0;
        rst_sw_n  = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_word   = '0;
        out_ready = 1'b1;
        cnt_clr   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n    = 1'b1;
        rst_sw_n = 1'b1;
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_out_word", out_word, 0);
        chk("reset_out_err", out_err, 0);
        chk("reset_syndrome", out_syndrome, 0);
        chk("reset_out_mode", out_mode, 0);
        chk("reset_cnt_corr", cnt_corr, 0);
        chk("reset_cnt_uncorr", cnt_uncorr, 0);
        @(negedge clk);

        // Encode 0x0B with junk in the ignored upper bits; check two-edge latency.
        send(1'b0, 8'hFB, 8'hAA, 2'b00, 3'd0);
        chk("latency_stage1", out_valid, 0);
        @(negedge clk);
        chk("latency_stage2", out_valid, 1);
        drain();

        send(1'b1, 8'hAA, 8'h0B, 2'b00, 3'd0);
        drain();
        send(1'b1, 8'h8A, 8'h0B, 2'b01, 3'b101);
        drain();
        chk("cnt_corr_after_bit5", cnt_corr, 1);
        send(1'b1, 8'hAB, 8'h0B, 2'b01, 3'd0);
        drain();
        chk("cnt_corr_after_bit0", cnt_corr, 2);
        send(1'b1, 8'hAC, 8'h0B, 2'b10, 3'b011);
        drain();
        chk("cnt_uncorr_after_double", cnt_uncorr, 1);
        chk("cnt_corr_unchanged", cnt_corr, 2);

        // Back-to-back interleaved encode/decode at one per cycle.
        t0 = $time;
        for (int i = 0; i < 6; i++) begin
            dd  = 4'($urandom_range(0, 15));
            tmp = m_encode(64'(dd), 4);
            if (i % 2 == 0) send(1'b0, {4'($urandom_range(0, 15)), dd}, tmp[7:0], 2'b00, 3'd0);
            else            send(1'b1, tmp[7:0], {4'b0, dd}, 2'b00, 3'd0);
        end
        chk("throughput_time", 64'($time - t0), 60);
        drain();

        // Backpressure: two accepted, third stalls until the consumer is ready.
        tmp = m_encode(64'd1, 4); e1 = tmp[7:0];
        tmp = m_encode(64'd2, 4); e2 = tmp[7:0];
        tmp = m_encode(64'd3, 4); e3 = tmp[7:0];
        out_ready = 1'b0;
        send(1'b0, 8'h01, e1, 2'b00, 3'd0);
        send(1'b0, 8'h02, e2, 2'b00, 3'd0);
        in_valid = 1'b1;
        in_mode  = 1'b0;
        in_word  = 8'h03;
        #1;
        chk("bp_in_ready_full", in_ready, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("bp_in_ready_held", in_ready, 0);
        chk("bp_out_valid_held", out_valid, 1);
        chk("bp_out_word_held", out_word, e1);
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_comb", in_ready, 1);
        mq_w.push_back(e3);
        mq_e.push_back(2'b00);
        mq_s.push_back(3'd0);
        mq_m.push_back(1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        drain();

        repeat (5) send(1'b1, 8'h8A, 8'h0B, 2'b01, 3'b101);
        drain();
        chk("cnt_corr_saturated", cnt_corr, 3);

        // Clear on the same edge as a corrected-decode handshake.
        out_ready = 1'b0;
        send(1'b1, 8'hAB, 8'h0B, 2'b01, 3'd0);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("clr_setup_out_valid", out_valid, 1);
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_priority_corr", cnt_corr, 0);
        chk("clr_priority_uncorr", cnt_uncorr, 0);
        drain();
        send(1'b1, 8'h8A, 8'h0B, 2'b01, 3'b101);
        drain();
        chk("cnt_corr_after_clear", cnt_corr, 1);

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        send(1'b0, 8'h01, e1, 2'b00, 3'd0);
        send(1'b0, 8'h02, e2, 2'b00, 3'd0);
        rst_n = 1'b0;
        mq_w.delete();
        mq_e.delete();
        mq_s.delete();
        mq_m.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midreset_out_valid", out_valid, 0);
        chk("midreset_in_ready", in_ready, 1);
        chk("midreset_out_word", out_word, 0);
        chk("midreset_out_err", out_err, 0);
        chk("midreset_syndrome", out_syndrome, 0);
        chk("midreset_out_mode", out_mode, 0);
        chk("midreset_cnt_corr", cnt_corr, 0);
        chk("midreset_cnt_uncorr", cnt_uncorr, 0);
        @(negedge clk);
        out_ready = 1'b1;
        send(1'b1, 8'hAB, 8'h0B, 2'b01, 3'd0);
        drain();
        chk("post_reset_cnt_corr", cnt_corr, 1);
        chk("main_outstanding", mq_w.size(), 0);

        n = 0;
        while (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done) && n < 30000) begin
            @(negedge clk);
            n++;
        end
        if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done)) begin
            checks++;
            errors++;
            $display("FAIL sweep_done: sweeps incomplete after %0d cycles, required complete", n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
